// File: rtl/mac_job_arbiter.sv
// Round-robin arbiter that sequences one requester's job at a time onto a shared
// 4x4 MAC controller: load A rows, load B rows, gap, start, wait for done, respond.
module mac_job_arbiter #(
  parameter int NREQ    = 4,
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*N*W-1:0]    a_row,
  input  logic [NREQ*N*W-1:0]    b_row,
  output logic [NREQ-1:0]        grant,
  output logic [$clog2(N)-1:0]   row_idx,
  output logic                   mac_load_A,
  output logic                   mac_load_B,
  output logic                   mac_start,
  output logic [N*W-1:0]         mac_a_row,
  output logic [N*W-1:0]         mac_b_row,
  input  logic                   mac_done,
  output logic [NREQ-1:0]        resp_valid,
  output logic                   resp_err,
  input  logic                   resp_ready
);
  localparam int PW = $clog2(NREQ);
  localparam int RW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam int NW = N*W;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, GAP, START, WAIT, RESP} state_t;

  state_t          r_state, w_next;
  logic [NREQ-1:0] r_grant;
  logic [PW-1:0]   r_rr_ptr;
  logic [RW-1:0]   r_row_idx;
  logic [TW-1:0]   r_tmo_cnt;
  logic            r_resp_err;
  logic            w_found;
  logic [PW-1:0]   w_win, w_scan;
  logic [NW-1:0]   w_a, w_b;
  logic            w_last_row, w_tmo_hit;

  assign w_last_row = (r_row_idx == RW'(N-1));
  assign w_tmo_hit  = (r_tmo_cnt == TW'(TIMEOUT-1));

  // First set request after the previous winner, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_scan  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_scan = PW'((int'(r_rr_ptr) + i) % NREQ);
      if (!w_found && req[w_scan]) begin
        w_found = 1'b1;
        w_win   = w_scan;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    mac_load_A = 1'b0;
    mac_load_B = 1'b0;
    mac_start  = 1'b0;
    resp_valid = '0;
    case (r_state)
      IDLE:   if (w_found) w_next = LOAD_A;
      LOAD_A: begin
        mac_load_A = 1'b1;
        if (w_last_row) w_next = LOAD_B;
      end
      LOAD_B: begin
        mac_load_B = 1'b1;
        if (w_last_row) w_next = GAP;
      end
      GAP:    w_next = START;
      START:  begin
        mac_start = 1'b1;
        w_next    = WAIT;
      end
      WAIT:   if (mac_done || w_tmo_hit) w_next = RESP;
      RESP:   begin
        resp_valid = r_grant;
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_grant    <= '0;
      r_rr_ptr   <= PW'(NREQ-1);
      r_row_idx  <= '0;
      r_tmo_cnt  <= '0;
      r_resp_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_found) begin
          r_grant   <= NREQ'(1) << w_win;
          r_rr_ptr  <= w_win;
          r_row_idx <= '0;
        end
        LOAD_A, LOAD_B: r_row_idx <= w_last_row ? '0 : r_row_idx + 1'b1;
        START: r_tmo_cnt <= '0;
        // done wins over the timeout when both land in the same cycle
        WAIT: begin
          if (mac_done)       r_resp_err <= 1'b0;
          else if (w_tmo_hit) r_resp_err <= 1'b1;
          else                r_tmo_cnt  <= r_tmo_cnt + 1'b1;
        end
        RESP: if (resp_ready) begin
          r_grant    <= '0;
          r_resp_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // AND-OR mux keyed on the one-hot grant; zero when idle.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (r_grant[r]) begin
        w_a = w_a | a_row[r*NW +: NW];
        w_b = w_b | b_row[r*NW +: NW];
      end
    end
  end

  assign grant     = r_grant;
  assign row_idx   = r_row_idx;
  assign resp_err  = r_resp_err;
  assign mac_a_row = w_a;
  assign mac_b_row = w_b;

  a_grant_oh: assert property (@(posedge clock) disable iff (!reset_n) $onehot0(r_grant));
  a_resp_oh:  assert property (@(posedge clock) disable iff (!reset_n) $onehot0(resp_valid));
  a_resp_own: assert property (@(posedge clock) disable iff (!reset_n)
                               (resp_valid != '0) |-> (r_grant == resp_valid));
  a_ctl_oh:   assert property (@(posedge clock) disable iff (!reset_n)
                               $onehot0({mac_load_A, mac_load_B, mac_start}));
endmodule

// File: tb/tb_mac_job_arbiter.sv
// Directed bench for mac_job_arbiter: expected grants/responses go into queues and
// a monitor pops them as the DUT presents them; a small MAC model drives done.
module tb_mac_job_arbiter;
  localparam int NREQ = 4, N = 4, W = 8, TIMEOUT = 64, NW = N*W;

  logic                clock = 1'b0;
  logic                reset_n;
  logic [NREQ-1:0]     req;
  logic [NREQ*NW-1:0]  a_row, b_row;
  logic [NREQ-1:0]     grant;
  logic [1:0]          row_idx;
  logic                mac_load_A, mac_load_B, mac_start;
  logic [NW-1:0]       mac_a_row, mac_b_row;
  logic                mac_done;
  logic [NREQ-1:0]     resp_valid;
  logic                resp_err;
  logic                resp_ready;
  bit                  done_en;

  int total = 0, bad = 0;
  logic [NREQ-1:0] exp_grant[$];
  logic [NREQ:0]   exp_resp[$];

  // per-job trace results
  int tj_nA, tj_nB, tj_nS, tj_fa, tj_la, tj_fb, tj_lb, tj_s, tj_rv;

  mac_job_arbiter #(.NREQ(NREQ), .N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .a_row(a_row), .b_row(b_row),
    .grant(grant), .row_idx(row_idx), .mac_load_A(mac_load_A), .mac_load_B(mac_load_B),
    .mac_start(mac_start), .mac_a_row(mac_a_row), .mac_b_row(mac_b_row),
    .mac_done(mac_done), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_ready(resp_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NW-1:0] pat_row(input int row, input int r, input bit isb);
    logic [NW-1:0] v;
    for (int e = 0; e < N; e++)
      v[e*W +: W] = 8'(row*64 + r*16 + e) ^ (isb ? 8'hFF : 8'h00);
    return v;
  endfunction

  function automatic int oh2i(input logic [NREQ-1:0] oh);
    int k = 0;
    for (int i = 0; i < NREQ; i++) if (oh[i]) k = i;
    return k;
  endfunction

  // Each requester presents the row the arbiter asks for.
  task automatic drive_rows();
    for (int r = 0; r < NREQ; r++) begin
      a_row[r*NW +: NW] = pat_row(int'(row_idx), r, 1'b0);
      b_row[r*NW +: NW] = pat_row(int'(row_idx), r, 1'b1);
    end
  endtask

  initial begin
    #0 drive_rows();
    forever begin
      @(row_idx);
      drive_rows();
    end
  end

  // MAC model: done rises 6 cycles after start and stays up until the job retires.
  initial begin
    mac_done = 1'b0;
    forever begin
      @(negedge clock);
      if (mac_start && done_en && reset_n) begin
        for (int i = 0; i < 6; i++) @(negedge clock);
        mac_done = 1'b1;
        while (grant != '0 && reset_n) @(negedge clock);
        mac_done = 1'b0;
      end
    end
  end

  // Monitor: grant rises and response handshakes are checked against the queues.
  initial begin
    logic [NREQ-1:0] prev = '0;
    logic [NREQ-1:0] eg;
    logic [NREQ:0]   er;
    forever begin
      @(negedge clock);
      #1;
      if (grant != '0 && prev == '0) begin
        if (exp_grant.size() == 0) chk("unexpected_grant", grant, '0);
        else begin
          eg = exp_grant.pop_front();
          chk("grant_seq", grant, eg);
        end
      end
      if (resp_valid != '0 && resp_ready) begin
        if (exp_resp.size() == 0) chk("unexpected_resp", {resp_valid, resp_err}, '0);
        else begin
          er = exp_resp.pop_front();
          chk("resp", {resp_valid, resp_err}, er);
        end
      end
      prev = grant;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Follow one job cycle by cycle; checks row data and optional backpressure hold.
  task automatic run_job(input logic [NREQ-1:0] owner, input logic [NREQ-1:0] extra,
                         input int hold, input int max);
    int cyc = 0, hcnt = 0, rowA = 0, rowB = 0, o;
    bit fin = 0;
    o = oh2i(owner);
    tj_nA = 0; tj_nB = 0; tj_nS = 0; tj_fa = 0; tj_la = 0;
    tj_fb = 0; tj_lb = 0; tj_s = 0; tj_rv = 0;
    while (!fin && cyc < max) begin
      @(negedge clock);
      cyc++;
      if (mac_load_A) begin
        if (tj_nA == 0) tj_fa = cyc;
        tj_la = cyc; tj_nA++;
        chk("mac_a_row", mac_a_row, pat_row(rowA, o, 1'b0));
        rowA++;
        req = req | extra;
      end
      if (mac_load_B) begin
        if (tj_nB == 0) tj_fb = cyc;
        tj_lb = cyc; tj_nB++;
        chk("mac_b_row", mac_b_row, pat_row(rowB, o, 1'b1));
        rowB++;
      end
      if (mac_start) begin tj_nS++; tj_s = cyc; end
      if (resp_valid != '0) begin
        if (tj_rv == 0) tj_rv = cyc;
        if (!resp_ready) begin
          chk("hold_resp_valid", resp_valid, owner);
          chk("hold_grant", grant, owner);
          hcnt++;
          if (hcnt >= hold) begin
            resp_ready = 1'b1;
            req = req & ~owner;
            fin = 1;
          end
        end else begin
          req = req & ~owner;
          fin = 1;
        end
      end
    end
    if (!fin) chk("job_timeout", 64'(cyc), 64'(max + 1));
  endtask

  initial begin
    int hs, h1, h2, cyc;
    bit seen;
    reset_n = 1'b0; req = '0; resp_ready = 1'b0; done_en = 1'b1;
    idle(2);
    // reset state
    chk("rst_grant", grant, '0);
    chk("rst_ctl", {mac_load_A, mac_load_B, mac_start, row_idx}, '0);
    chk("rst_resp", {resp_valid, resp_err}, '0);
    reset_n = 1'b1;
    idle(1);

    // 1: reset during LOAD_B, then req[2] alone wins
    req = 4'b0001; resp_ready = 1'b1;
    exp_grant.push_back(4'b0001);
    seen = 0; cyc = 0;
    while (!seen && cyc < 30) begin @(negedge clock); cyc++; seen = mac_load_B; end
    chk("reach_load_b", seen, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midjob_rst_grant", grant, '0);
    chk("midjob_rst_ctl", {mac_load_A, mac_load_B, mac_start, row_idx}, '0);
    chk("midjob_rst_data", {mac_a_row, mac_b_row}, '0);
    chk("midjob_rst_resp", {resp_valid, resp_err}, '0);
    req = 4'b0100;
    @(negedge clock);
    reset_n = 1'b1;
    exp_grant.push_back(4'b0100);
    exp_resp.push_back({4'b0100, 1'b0});
    run_job(4'b0100, '0, 0, 60);

    // 2: single job shape
    idle(2);
    req = 4'b0010;
    exp_grant.push_back(4'b0010);
    exp_resp.push_back({4'b0010, 1'b0});
    run_job(4'b0010, '0, 0, 60);
    chk("t2_first_load_a", tj_fa, 1);
    chk("t2_nA", tj_nA, 4);
    chk("t2_nB", tj_nB, 4);
    chk("t2_nS", tj_nS, 1);
    chk("t2_a_to_b", tj_fb, tj_la + 1);
    chk("t2_gap", tj_s, tj_lb + 2);
    chk("t2_wait", tj_rv, tj_s + 7);

    // 3: round robin with all requests held
    idle(2);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    idle(1);
    foreach (exp_grant[i]) ;
    begin
      logic [NREQ-1:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      foreach (seq[i]) begin
        exp_grant.push_back(seq[i]);
        exp_resp.push_back({seq[i], 1'b0});
      end
    end
    req = 4'b1111; resp_ready = 1'b1;
    hs = 0; h1 = 0; h2 = 0; cyc = 0;
    while (hs < 5 && cyc < 400) begin
      @(negedge clock); cyc++;
      if (resp_valid != '0 && resp_ready) begin
        hs++;
        if (hs == 1) h1 = cyc;
        if (hs == 2) h2 = cyc;
        if (hs == 5) req = '0;
      end
    end
    chk("rr_handshakes", hs, 5);
    chk("rr_back_to_back", h2 - h1, 18);

    // 4: timeout with done never asserted
    idle(2);
    done_en = 1'b0;
    req = 4'b0100;
    exp_grant.push_back(4'b0100);
    exp_resp.push_back({4'b0100, 1'b1});
    run_job(4'b0100, '0, 0, 200);
    chk("t4_nS", tj_nS, 1);
    chk("t4_wait64", tj_rv, tj_s + 65);
    done_en = 1'b1;

    // 5: backpressure; req[3] raised mid-job must wait for the handshake
    idle(2);
    resp_ready = 1'b0;
    req = 4'b0001;
    exp_grant.push_back(4'b0001);
    exp_resp.push_back({4'b0001, 1'b0});
    exp_grant.push_back(4'b1000);
    exp_resp.push_back({4'b1000, 1'b0});
    run_job(4'b0001, 4'b1000, 10, 80);
    chk("t5_req3_pending", req, 4'b1000);
    run_job(4'b1000, '0, 0, 60);

    // 6: data mux for owner 2 (row data checked inside run_job)
    idle(2);
    req = 4'b0100;
    exp_grant.push_back(4'b0100);
    exp_resp.push_back({4'b0100, 1'b0});
    run_job(4'b0100, '0, 0, 60);
    chk("t6_nA", tj_nA, 4);

    idle(3);
    chk("sb_drained", 64'(exp_grant.size() + exp_resp.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
